// File: rtl/seq_ripple_adder.sv
// rtl/seq_ripple_adder.sv - multi-cycle adder, SLICE bits per clock, valid/ready handshake
// Optional subtract mode (port sub) is enabled by defining SEQ_ADDER_SUB_EN.
module seq_ripple_adder #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SEQ_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = WIDTH / SLICE;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic             accept;
    logic             last;
    logic [KW-1:0]    k;
    logic             carry;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_nx;
    logic [SLICE:0]   slice_sum;
    logic [WIDTH-1:0] eff_b;
    logic             eff_cin;
    int               base;

    // Subtraction is a + ~b + ~cin, so only the captured operand and carry differ.
    always_comb begin
`ifdef SEQ_ADDER_SUB_EN
        eff_b   = sub ? ~b : b;
        eff_cin = sub ? ~cin : cin;
`else
        eff_b   = b;
        eff_cin = cin;
`endif
    end

    always_comb begin
        base      = int'(k) * SLICE;
        last      = (int'(k) == N - 1);
        slice_sum = {1'b0, op_a[base +: SLICE]} + {1'b0, op_b[base +: SLICE]}
                  + {{SLICE{1'b0}}, carry};
        acc_nx                 = acc;
        acc_nx[base +: SLICE]  = slice_sum[SLICE-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept   = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (last) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Published result registers load only on the final slice, so they stay
    // frozen through DONE and across the next operation's RUN phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a  <= '0;
            op_b  <= '0;
            acc   <= '0;
            carry <= 1'b0;
            k     <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else if (accept) begin
            op_a  <= a;
            op_b  <= eff_b;
            carry <= eff_cin;
            acc   <= '0;
            k     <= '0;
        end else if (state == RUN) begin
            acc   <= acc_nx;
            carry <= slice_sum[SLICE];
            if (last) begin
                k    <= '0;
                sum  <= acc_nx;
                cout <= slice_sum[SLICE];
                ovf  <= (op_a[WIDTH-1] == op_b[WIDTH-1]) && (acc_nx[WIDTH-1] != op_a[WIDTH-1]);
            end else begin
                k <= k + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seq_ripple_adder.sv
// tb/tb_seq_ripple_adder.sv - scoreboard bench for seq_ripple_adder (16/4 and 8/8 instances)
module tb_seq_ripple_adder;

`ifdef SEQ_ADDER_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    typedef struct packed {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  iv, ordy, cin_v, sub_v;
    logic [15:0] a16, b16;
    logic [7:0]  a8, b8;
    logic        ir16, ov16, co16, of16;
    logic [15:0] s16;
    logic        ir8, ov8, co8, of8;
    logic [7:0]  s8;
    logic [1:0]  ir_v, ov_v;
    logic [15:0] sum_v [2];

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;

    always #5 clk = ~clk;

    seq_ripple_adder #(.WIDTH(16), .SLICE(4)) dut16 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir16),
        .a(a16), .b(b16), .cin(cin_v[0]),
`ifdef SEQ_ADDER_SUB_EN
        .sub(sub_v[0]),
`endif
        .out_valid(ov16), .out_ready(ordy[0]), .sum(s16), .cout(co16), .ovf(of16)
    );

    seq_ripple_adder #(.WIDTH(8), .SLICE(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir8),
        .a(a8), .b(b8), .cin(cin_v[1]),
`ifdef SEQ_ADDER_SUB_EN
        .sub(sub_v[1]),
`endif
        .out_valid(ov8), .out_ready(ordy[1]), .sum(s8), .cout(co8), .ovf(of8)
    );

    assign ir_v     = {ir8, ir16};
    assign ov_v     = {ov8, ov16};
    assign sum_v[0] = s16;
    assign sum_v[1] = {8'h00, s8};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: exact integer arithmetic, then reduce modulo 2^w.
    function automatic exp_t model(input int w, input logic [15:0] av, input logic [15:0] bv,
                                   input logic c, input logic s);
        longint m, ua, ub, sa, sb, u, sv;
        exp_t   r;
        m  = longint'(1) << w;
        ua = longint'(av) & (m - 1);
        ub = longint'(bv) & (m - 1);
        sa = (ua >= m / 2) ? ua - m : ua;
        sb = (ub >= m / 2) ? ub - m : ub;
        if (s) begin
            u      = ua - ub - longint'(c);
            sv     = sa - sb - longint'(c);
            r.cout = (u >= 0);
        end else begin
            u      = ua + ub + longint'(c);
            sv     = sa + sb + longint'(c);
            r.cout = (u >= m);
        end
        u      = ((u % m) + m) % m;
        r.sum  = 16'(u);
        r.ovf  = (sv >= m / 2) || (sv < -(m / 2));
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst && ov16 && ordy[0]) begin
            if (q0.size() == 0) begin
                check("unexpected_out16", 1, 0);
            end else begin
                e0 = q0.pop_front();
                check("sum16", s16, e0.sum);
                check("cout16", co16, e0.cout);
                check("ovf16", of16, e0.ovf);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && ov8 && ordy[1]) begin
            if (q1.size() == 0) begin
                check("unexpected_out8", 1, 0);
            end else begin
                e1 = q1.pop_front();
                check("sum8", s8, e1.sum[7:0]);
                check("cout8", co8, e1.cout);
                check("ovf8", of8, e1.ovf);
            end
        end
    end

    task automatic drive(input int d, input logic [15:0] av, input logic [15:0] bv,
                         input logic c, input logic s);
        if (d == 0) begin
            a16 = av;
            b16 = bv;
        end else begin
            a8 = av[7:0];
            b8 = bv[7:0];
        end
        cin_v[d] = c;
        sub_v[d] = s;
    endtask

    task automatic drive_junk(input int d);
        drive(d, 16'($urandom), 16'($urandom), 1'($urandom), SUB_EN & 1'($urandom));
    endtask

    task automatic op(input int d, input logic [15:0] av, input logic [15:0] bv,
                      input logic c, input logic s, input int hold);
        exp_t e;
        int   w, n, lat;
        w = (d != 0) ? 8 : 16;
        n = (d != 0) ? 1 : 4;
        e = model(w, av, bv, c, s);
        check("in_ready_before_op", ir_v[d], 1);
        drive(d, av, bv, c, s);
        iv[d] = 1'b1;
        @(posedge clk);
        #1;
        iv[d] = 1'b0;
        if (d != 0) q1.push_back(e);
        else        q0.push_back(e);
        lat = 0;
        while (!ov_v[d] && lat < n + 4) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", lat, n);
        for (int i = 0; i < hold; i++) begin
            drive_junk(d);
            iv[d] = (i % 2 == 0);
            @(posedge clk);
            #1;
            check("hold_out_valid", ov_v[d], 1);
            check("hold_in_ready", ir_v[d], 0);
            check("hold_sum", sum_v[d], (d != 0) ? {8'h00, e.sum[7:0]} : e.sum);
        end
        drive_junk(d);
        iv[d]   = 1'b1;
        ordy[d] = 1'b1;
        @(posedge clk);
        #1;
        ordy[d] = 1'b0;
        iv[d]   = 1'b0;
        check("valid_after_take", ov_v[d], 0);
        check("ready_after_take", ir_v[d], 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int bad;
        rst   = 1'b1;
        iv    = '0;
        ordy  = '0;
        cin_v = '0;
        sub_v = '0;
        a16 = '0; b16 = '0; a8 = '0; b8 = '0;
        #1;
        check("rst_in_ready16", ir16, 1);
        check("rst_out_valid16", ov16, 0);
        check("rst_sum16", s16, 0);
        check("rst_cout16", co16, 0);
        check("rst_ovf16", of16, 0);
        check("rst_sum8", s8, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("ready_first_cycle16", ir16, 1);
        check("ready_first_cycle8", ir8, 1);

        op(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
        op(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1);
        op(0, 16'h1234, 16'h1111, 1'b1, 1'b0, 0);
        op(0, 16'hA5A5, 16'h5A5A, 1'b1, 1'b0, 3);
        op(0, 16'h8000, 16'h8000, 1'b0, 1'b0, 0);
        op(1, 16'h00C8, 16'h0064, 1'b0, 1'b0, 0);
        op(1, 16'h007F, 16'h0001, 1'b0, 1'b0, 2);
        if (SUB_EN) begin
            op(0, 16'h0005, 16'h0007, 1'b0, 1'b1, 0);
            op(0, 16'h8000, 16'h0001, 1'b0, 1'b1, 1);
            op(0, 16'h0007, 16'h0005, 1'b1, 1'b1, 0);
            op(1, 16'h0080, 16'h0001, 1'b0, 1'b1, 0);
        end

        // Reset in the middle of RUN (slice index 2) must drop the operation.
        drive(0, 16'h4321, 16'h1234, 1'b0, 1'b0);
        iv[0] = 1'b1;
        @(posedge clk);
        #1;
        iv[0] = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        #1;
        check("midrun_rst_out_valid", ov16, 0);
        check("midrun_rst_in_ready", ir16, 1);
        check("midrun_rst_sum", s16, 0);
        check("midrun_rst_cout", co16, 0);
        check("midrun_rst_ovf", of16, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("ready_after_midrun_rst", ir16, 1);
        bad = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (ov16) bad++;
        end
        check("no_valid_after_rst", bad, 0);
        op(0, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 0);

        for (int i = 0; i < 40; i++) begin
            op(0, 16'($urandom), 16'($urandom), 1'($urandom), SUB_EN & 1'($urandom),
               int'($urandom_range(0, 3)));
        end
        for (int i = 0; i < 20; i++) begin
            op(1, 16'($urandom), 16'($urandom), 1'($urandom), SUB_EN & 1'($urandom),
               int'($urandom_range(0, 2)));
        end

        repeat (3) @(posedge clk);
        #1;
        check("queue16_drained", q0.size(), 0);
        check("queue8_drained", q1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_ripple_adder.md
SEQ_RIPPLE_ADDER -- requirements
Module: seq_ripple_adder

Interface
REQ-001 Parameter WIDTH, default 16, operand and result width in bits.
REQ-002 Parameter SLICE, default 4, bits added per clock cycle; WIDTH SHALL be an integer multiple of SLICE; N = WIDTH/SLICE.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  operands and cin are valid.
REQ-006 in_ready  output  1  block accepts a new operation.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 cin  input  1  carry-in; borrow-in when subtracting.
REQ-010 sub  input  1  1 = subtract; present only with SEQ_ADDER_SUB_EN.
REQ-011 out_valid  output  1  result valid.
REQ-012 out_ready  input  1  consumer takes result.
REQ-013 sum  output  WIDTH  registered result.
REQ-014 cout  output  1  carry out of MSB.
REQ-015 ovf  output  1  two's-complement signed overflow.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-017 IDLE: in_ready=1, out_valid=0; when in_valid=1, the block SHALL capture a, b and the carry-in at that edge and go to RUN with slice index k=0.
REQ-018 RUN: each cycle, the block SHALL add slice k of A and B plus the carry register, store the SLICE-bit result in slice k of an internal result register, update the carry register and increment k. in_ready=0.
REQ-019 After slice N-1, the block SHALL load sum, cout and ovf and enter DONE; out_valid SHALL rise exactly N rising edges after the accepting edge.
REQ-020 ovf SHALL be (MSB of effective A == MSB of effective B) and (MSB of sum != MSB of effective A).
REQ-021 DONE: out_valid=1, in_ready=0; sum/cout/ovf SHALL remain stable until out_ready=1, then the block SHALL return to IDLE on that edge.
REQ-022 in_valid while in RUN or DONE SHALL be ignored; there is no same-cycle handoff from DONE to acceptance (in_ready rises the cycle after the result is taken).
REQ-023 Arithmetic SHALL be modulo 2^WIDTH; the carry from slice N-1 is cout, with no wrap into slice 0.
REQ-024 SLICE=WIDTH SHALL be legal and give 1-cycle latency.
REQ-025 sum/cout/ovf SHALL change only on entry to DONE and on reset.

Reset
REQ-026 rst=1 SHALL immediately force IDLE with in_ready=1, out_valid=0, sum=0, cout=0, ovf=0 and k=0, and clear the carry register.
REQ-027 Reset during RUN or DONE SHALL discard the operation in flight; no out_valid SHALL follow for it.
REQ-028 in_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-029 Macro SEQ_ADDER_SUB_EN defined: port sub exists; it is captured with the operands; when sub=1 the block SHALL use effective B = ~b and effective carry-in = ~cin, computing a-b-cin; cout=1 means no borrow.
REQ-030 Macro SEQ_ADDER_SUB_EN undefined: port sub is absent; the block is add-only with effective B = b and effective carry-in = cin.

Verification
REQ-031 WIDTH=16, SLICE=4: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0; out_valid exactly 4 edges after acceptance.
REQ-032 a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1; a=0x1234, b=0x1111, cin=1 -> sum=0x2346, cout=0.
REQ-033 Backpressure: hold out_ready=0 for 3 cycles in DONE while toggling in_valid with new operands -> sum held, in_ready=0, no new capture; result taken on the out_ready edge, in_ready=1 the next cycle.
REQ-034 Assert rst at RUN slice k=2 -> outputs zero immediately, IDLE, no out_valid; a new operation after reset completes correctly.
REQ-035 With SEQ_ADDER_SUB_EN: a=0x0005, b=0x0007, cin=0, sub=1 -> sum=0xFFFE, cout=0; a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, ovf=1.
REQ-036 WIDTH=8, SLICE=8: a=0xC8, b=0x64 -> sum=0x2C, cout=1, out_valid 1 edge after acceptance.
